// File: rtl/clk_div_pkg.sv
// Shared types and default sizing for the clock-divider period meter.
package clk_div_pkg;

    localparam int CNT_W_DEF    = 8;
    localparam int LOCK_CNT_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/sig_edge_det.sv
// Rising-edge detector for the measured square wave.
// Optional two-stage input synchroniser enabled by CLK_DIV_METER_SYNC_EN.
module sig_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise
);

    logic s_src;
    logic s_d;
    logic s_dd;

`ifdef CLK_DIV_METER_SYNC_EN
    logic [1:0] sync_reg;

    // Two flops settle a possibly asynchronous input before edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], sig_in};
        end
    end

    assign s_src = sync_reg[1];
`else
    assign s_src = sig_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_d  <= 1'b0;
            s_dd <= 1'b0;
        end else begin
            s_d  <= s_src;
            s_dd <= s_d;
        end
    end

    assign rise = s_d & ~s_dd;

endmodule

// File: rtl/clk_div_meter.sv
// Measures rise-to-rise period of a slow clock-derived wave, declares lock on
// repeated equal periods and pulses timeout when edges stop.
module clk_div_meter
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int               M_W         = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [M_W-1:0]   LOCK_TARGET = M_W'(LOCK_CNT);

    logic             rise;

    state_t           state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [M_W-1:0]   match_reg,   match_next;
    logic [CNT_W-1:0] period_reg,  period_next;
    logic             valid_reg,   valid_next;
    logic             timeout_reg, timeout_next;
    logic             locked_reg,  locked_next;
    logic [M_W-1:0]   match_inc;

    sig_edge_det u_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .rise   (rise)
    );

    assign match_inc = match_reg + M_W'(1);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        match_next   = match_reg;
        period_next  = period_reg;
        valid_next   = 1'b0;
        timeout_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rise) begin
                    state_next = MEASURE;
                    cnt_next   = CNT_ONE;
                    match_next = '0;
                end
            end
            MEASURE, LOCKED: begin
                if (rise) begin
                    // A rise coinciding with CNT_MAX is still a valid measurement.
                    cnt_next    = CNT_ONE;
                    period_next = cnt_reg;
                    valid_next  = 1'b1;
                    if (cnt_reg == period_reg) begin
                        if (state_reg == MEASURE) begin
                            match_next = match_inc;
                            if (match_inc == LOCK_TARGET) begin
                                state_next = LOCKED;
                            end
                        end
                    end else begin
                        match_next = '0;
                        state_next = MEASURE;
                    end
                end else if (cnt_reg == CNT_MAX) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                    period_next  = '0;
                    match_next   = '0;
                    cnt_next     = cnt_reg + CNT_ONE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                match_next = '0;
            end
        endcase

        locked_next = (state_next == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            match_reg   <= '0;
            period_reg  <= '0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            locked_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            match_reg   <= match_next;
            period_reg  <= period_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
            locked_reg  <= locked_next;
        end
    end

    assign period       = period_reg;
    assign period_valid = valid_reg;
    assign locked       = locked_reg;
    assign timeout      = timeout_reg;

endmodule
